mem_access_unit: RTL

- Multi-cycle data-memory access stage that sits directly upstream of the writeback data-select mux.
- Takes the MEM-stage opcode, effective address and store data, and runs a req/ack transaction on the data-memory port.
- For loads, returns aligned and sign/zero-extended load data on Ddata.
- Holds stall high to freeze the pipeline while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Multi-cycle data-memory access stage feeding the writeback data-select mux.
// Decodes the MEM-stage load/store opcode, checks alignment, runs one req/ack
// transaction on the data-memory port and returns the aligned, extended load
// result on Ddata.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request that has waited
// TIMEOUT_CYCLES REQ cycles without mem_ack (bus_err pulse). Without it the
// request waits indefinitely and bus_err is tied 0.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, opcode       MEM-stage valid + opcode (start sampled in IDLE only)
//   addr, Rt            effective address, store data
//   mem_req/we/addr/be/wdata, mem_ack/rdata   data-memory port
//   Ddata               registered extended load result
//   done                1-cycle pulse, access complete
//   stall               pipeline hold
//   misalign            1-cycle pulse, misaligned access rejected
//   bus_err             1-cycle pulse, request timed out
module mem_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       Rt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       Ddata,
    output logic              done,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_ERR, S_TOUT} state_t;

    // access size encoding
    localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

    state_t      r_state, w_next;
    logic        w_load, w_store, w_sext, w_misal, w_go;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ldval;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    logic              r_load, r_sext, r_we;
    logic [1:0]        r_size, r_lo;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata, r_ddata;
    logic              w_tout;

    // opcode decode
    always_comb begin
        w_load  = 1'b0;
        w_store = 1'b0;
        w_sext  = 1'b0;
        w_size  = SZ_W;
        case (opcode)
            6'b100000: begin w_load = 1'b1; w_size = SZ_B; w_sext = 1'b1; end
            6'b100001: begin w_load = 1'b1; w_size = SZ_H; w_sext = 1'b1; end
            6'b100011: begin w_load = 1'b1; w_size = SZ_W; end
            6'b100100: begin w_load = 1'b1; w_size = SZ_B; end
            6'b100101: begin w_load = 1'b1; w_size = SZ_H; end
            6'b101000: begin w_store = 1'b1; w_size = SZ_B; end
            6'b101001: begin w_store = 1'b1; w_size = SZ_H; end
            6'b101011: begin w_store = 1'b1; w_size = SZ_W; end
            default: ;
        endcase
    end

    always_comb begin
        w_misal = ((w_size == SZ_H) && addr[0]) || ((w_size == SZ_W) && (addr[1:0] != 2'b00));
        w_go    = start && (w_load || w_store);
        case (w_size)
            SZ_B:    begin w_be = 4'b0001 << addr[1:0];                  w_wdata = {4{Rt[7:0]}};  end
            SZ_H:    begin w_be = addr[1] ? 4'b1100 : 4'b0011;           w_wdata = {2{Rt[15:0]}}; end
            default: begin w_be = 4'b1111;                               w_wdata = Rt;            end
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_cnt;

    // Zero outside REQ, so it is already clear on REQ entry. The cycle in
    // which it would reach TIMEOUT_CYCLES is the abort cycle.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_REQ) r_cnt <= '0;
        else if (!mem_ack)           r_cnt <= r_cnt + 1'b1;
    end
    assign w_tout  = (r_state == S_REQ) && !mem_ack && (r_cnt == TO_LAST);
    assign bus_err = (r_state == S_TOUT);
`else
    assign w_tout  = 1'b0;
    assign bus_err = 1'b0;
`endif

    // next state and stall
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next = w_misal ? S_ERR : S_REQ;
                    stall  = !w_misal;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (mem_ack)     w_next = S_RESP;  // ack beats a same-cycle timeout
                else if (w_tout) w_next = S_TOUT;
            end
            S_ERR:   begin stall = 1'b1; w_next = S_IDLE; end
            S_TOUT:  begin stall = 1'b1; w_next = S_IDLE; end
            default: w_next = S_IDLE;
        endcase
    end

    // load extraction from the returned word
    always_comb begin
        w_byte = mem_rdata[{r_lo, 3'b000} +: 8];
        w_half = r_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_size)
            SZ_B:    w_ldval = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_H:    w_ldval = {{16{r_sext & w_half[15]}}, w_half};
            default: w_ldval = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_sext  <= 1'b0;
            r_size  <= SZ_W;
            r_lo    <= 2'b00;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'h0;
            r_ddata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_go && !w_misal) begin
                r_load  <= w_load;
                r_sext  <= w_sext;
                r_size  <= w_size;
                r_lo    <= addr[1:0];
                r_we    <= w_store;
                r_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (r_state == S_REQ && mem_ack && r_load)
                r_ddata <= w_ldval;
        end
    end

    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign Ddata     = r_ddata;
    assign done      = (r_state == S_RESP);
    assign misalign  = (r_state == S_ERR);

endmodule
